// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic reduce unit: op encoding, base-op mapping
// and the control FSM state type.
package logic_ops_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic [1:0] {B_AND, B_OR, B_XOR} base_t;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   function automatic logic is_inverting(input logic [2:0] op);
      return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
   endfunction

   function automatic logic is_illegal(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   // Illegal encodings 6/7 fall back to OR.
   function automatic base_t base_op(input logic [2:0] op);
      case (op)
         OP_AND, OP_NAND: return B_AND;
         OP_XOR, OP_XNOR: return B_XOR;
         default:         return B_OR;
      endcase
   endfunction

endpackage

// File: rtl/logic_vec_reduce.sv
// Combinational fold of N_IN WIDTH-bit operands under a base bitwise op.
module logic_vec_reduce
   import logic_ops_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 2
) (
   input  logic [N_IN*WIDTH-1:0] ops_i,
   input  base_t                 bop_i,
   output logic [WIDTH-1:0]      red_o
);

   logic [WIDTH-1:0] r;

   always_comb begin
      r = ops_i[WIDTH-1:0];
      for (int k = 1; k < N_IN; k++) begin
         case (bop_i)
            B_AND:   r = r & ops_i[k*WIDTH +: WIDTH];
            B_XOR:   r = r ^ ops_i[k*WIDTH +: WIDTH];
            default: r = r | ops_i[k*WIDTH +: WIDTH];
         endcase
      end
   end

   assign red_o = r;

endmodule

// File: rtl/logic_reduce_unit.sv
// Registered N-input bitwise reducer with single-beat and multi-beat
// accumulate modes behind valid/ready handshakes.
module logic_reduce_unit
   import logic_ops_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [2:0]            in_op,
   input  logic                  in_acc,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_any,
   output logic                  out_all,
   output logic [CNT_W-1:0]      out_beats,
   output logic                  out_err
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d, data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, beats_q, beats_d;
   logic             err_q, err_d, oerr_q, oerr_d;

   logic [2:0]       op_eff;
   logic [WIDTH-1:0] beat_red, acc_comb;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;

   // Mid-packet the latched op governs; otherwise the incoming op does.
   assign op_eff  = (state_q == S_ACCUM) ? op_q : in_op;
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;

   assign out_valid = (state_q == S_HOLD);
   assign in_ready  = (state_q != S_HOLD) | out_ready;
   assign accept    = in_valid & in_ready;

   logic_vec_reduce #(.WIDTH(WIDTH), .N_IN(N_IN)) u_beat (
      .ops_i (in_data),
      .bop_i (base_op(op_eff)),
      .red_o (beat_red)
   );

   logic_vec_reduce #(.WIDTH(WIDTH), .N_IN(2)) u_acc (
      .ops_i ({beat_red, acc_q}),
      .bop_i (base_op(op_q)),
      .red_o (acc_comb)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      data_d  = data_q;
      beats_d = beats_q;
      oerr_d  = oerr_q;
      if (out_valid && out_ready) state_d = S_IDLE;
      if (accept) begin
         if (state_q == S_ACCUM) begin
            acc_d = acc_comb;
            cnt_d = cnt_inc;
            if (in_last) begin
               data_d  = is_inverting(op_q) ? ~acc_comb : acc_comb;
               beats_d = cnt_inc;
               oerr_d  = err_q;
               state_d = S_HOLD;
            end
         end else begin
            // IDLE, or HOLD with the held result consumed this same cycle.
            op_d  = in_op;
            acc_d = beat_red;
            cnt_d = ONE;
            err_d = is_illegal(in_op);
            if (!in_acc || in_last) begin
               data_d  = is_inverting(in_op) ? ~beat_red : beat_red;
               beats_d = ONE;
               oerr_d  = is_illegal(in_op);
               state_d = S_HOLD;
            end else begin
               state_d = S_ACCUM;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_AND;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         beats_q <= '0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         data_q  <= data_d;
         beats_q <= beats_d;
         oerr_q  <= oerr_d;
      end
   end

   assign out_data  = data_q;
   assign out_beats = beats_q;
   assign out_err   = oerr_q;
   assign out_any   = |data_q;
   assign out_all   = &data_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit: a default-width instance and a
// CNT_W=2 instance share stimulus so counter saturation is visible.
module tb_logic_reduce_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [2:0]  in_op = '0;
   logic        in_acc = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic       in_ready, out_valid, out_any, out_all, out_err;
   logic [7:0] out_data, out_beats;
   logic       s_in_ready, s_out_valid, s_out_any, s_out_all, s_out_err;
   logic [7:0] s_out_data;
   logic [1:0] s_out_beats;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   logic_reduce_unit #(.WIDTH(8), .N_IN(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_any(out_any), .out_all(out_all), .out_beats(out_beats),
      .out_err(out_err)
   );

   logic_reduce_unit #(.WIDTH(8), .N_IN(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_any(s_out_any), .out_all(s_out_all), .out_beats(s_out_beats),
      .out_err(s_out_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one beat, wait (bounded) for acceptance, sample 1 time unit after the edge.
   task automatic send(input logic [7:0] d1, input logic [7:0] d0, input logic [2:0] op,
                       input logic acc, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = {d1, d0};
      in_op    = op;
      in_acc   = acc;
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("drain_valid", out_valid, 0);
   endtask

   logic [3:0] tt [6];

   initial begin
      // Truth table per op, bit index = {b1,b0}
      tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110;
      tt[3] = 4'b0111; tt[4] = 4'b0001; tt[5] = 4'b1001;

      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_any", out_any, 0);
      chk("rst_all", out_all, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_beats", out_beats, 0);
      chk("rst_err", out_err, 0);

      // 1: single-beat OR
      send(8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'hFF);
      chk("t1_all", out_all, 1);
      chk("t1_any", out_any, 1);
      chk("t1_beats", out_beats, 1);
      chk("t1_err", out_err, 0);
      drain();

      // 2: 1-bit truth tables, back to back
      for (int op = 0; op < 6; op++) begin
         for (int v = 0; v < 4; v++) begin
            send({7'b0, v[1]}, {7'b0, v[0]}, op[2:0], 1'b0, 1'b0);
            chk($sformatf("t2_op%0d_in%0d", op, v), out_data[0], tt[op][v]);
            chk("t2_err", out_err, 0);
         end
      end
      send(8'h00, 8'h01, 3'd6, 1'b0, 1'b0);
      chk("t2_ill_data", out_data, 8'h01);
      chk("t2_ill_err", out_err, 1);
      send(8'h00, 8'h01, 3'd0, 1'b0, 1'b0);
      chk("t2_err_clr", out_err, 0);
      drain();

      // 3: XOR accumulate, op change mid-packet ignored
      send(8'h02, 8'h01, 3'd2, 1'b1, 1'b0);
      chk("t3_b1_valid", out_valid, 0);
      send(8'h00, 8'h04, 3'd0, 1'b0, 1'b0);
      chk("t3_b2_valid", out_valid, 0);
      send(8'h00, 8'h10, 3'd0, 1'b0, 1'b1);
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 8'h17);
      chk("t3_beats", out_beats, 3);
      chk("t3_err", out_err, 0);
      drain();

      // illegal op latched at packet start acts as OR and flags the packet
      send(8'h00, 8'h01, 3'd7, 1'b1, 1'b0);
      send(8'h02, 8'h00, 3'd0, 1'b1, 1'b1);
      chk("ta_data", out_data, 8'h03);
      chk("ta_err", out_err, 1);
      chk("ta_beats", out_beats, 2);
      drain();

      // 4: backpressure, then consume+accept in one cycle
      out_ready = 1'b0;
      send(8'hA0, 8'h05, 3'd1, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = {8'hFF, 8'h0F}; in_op = 3'd2; in_acc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_ready", in_ready, 0);
         chk("t4_hold", out_data, 8'hA5);
         chk("t4_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("t4_ready_up", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t4_next_valid", out_valid, 1);
      chk("t4_next_data", out_data, 8'hF0);
      chk("t4_next_beats", out_beats, 1);
      drain();

      // 5: six-beat AND packet, counter saturation on the narrow instance
      for (int i = 0; i < 6; i++) begin
         send(8'hFF, 8'hFF, 3'd0, 1'b1, i == 5);
         if (i < 5) chk("t5_nov", out_valid, 0);
      end
      chk("t5_data", out_data, 8'hFF);
      chk("t5_beats", out_beats, 6);
      chk("t5_sat_beats", s_out_beats, 3);
      chk("t5_sat_data", s_out_data, 8'hFF);
      chk("t5_sat_all", s_out_all, 1);
      drain();

      // 6: reset mid-accumulate discards the packet
      send(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
      send(8'h44, 8'h88, 3'd1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_data", out_data, 0);
      chk("t6_rst_beats", out_beats, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("t6_quiet", out_valid, 0);
      end
      send(8'h0F, 8'h3C, 3'd0, 1'b0, 1'b0);
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 8'h0C);
      chk("t6_beats", out_beats, 1);
      chk("t6_all", out_all, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
